wav_stream_player: RTL

Streams a canonical 44-byte-header PCM WAV image from byte-addressed DDRAM and produces signed 16-bit mono samples at the file's own sample rate. It sits directly upstream of the top-level audio mix/saturation stage and drives the DDRAM read port (addr/rd/ready) through the same byte-read handshake as the loader. It replaces the ad-hoc wave playback path.

---
 rtl/wav_pkg.sv | 15 +
 rtl/wav_rate_gen.sv | 20 ++
 rtl/wav_stream_player.sv | 98 +++++++++
 3 files changed

// File: rtl/wav_pkg.sv
// wav_pkg: FSM states, canonical WAV header layout and magic values shared by the player
package wav_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_HDR = 3'd1, ST_FETCH = 3'd2, ST_HOLD = 3'd3, ST_DONE = 3'd4, ST_ERROR = 3'd5;
  localparam logic [5:0] RIFF_OFS = 6'd0, WAVE_OFS = 6'd8, FMT_OFS = 6'd20, CH_OFS = 6'd22, RATE_OFS = 6'd24;
  localparam logic [5:0] BITS_OFS = 6'd34, SIZE_OFS = 6'd40, DATA_OFS = 6'd44;
  localparam logic [31:0] RIFF_MAGIC = 32'h4646_4952, WAVE_MAGIC = 32'h4556_4157;
  localparam logic [15:0] FMT_PCM = 16'd1;
  // true when header byte i is either unchecked or matches its required value
  function automatic logic hdr_byte_ok(input logic [5:0] i, input logic [7:0] b);
    if (i[5:2] == RIFF_OFS[5:2]) return b == RIFF_MAGIC[{i[1:0], 3'b000} +: 8];
    if (i[5:2] == WAVE_OFS[5:2]) return b == WAVE_MAGIC[{i[1:0], 3'b000} +: 8];
    if (i[5:1] == FMT_OFS[5:1]) return b == FMT_PCM[{i[0], 3'b000} +: 8];
    return 1'b1;
  endfunction
endpackage

// File: rtl/wav_rate_gen.sv
// wav_rate_gen: phase accumulator emitting rate ticks per CLK_HZ cycles
module wav_rate_gen #(
  parameter int unsigned CLK_HZ = 24000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [31:0] rate,
  input  logic        enable,
  input  logic        clear,
  output logic        tick
);
  logic [31:0] acc;
  logic [32:0] sum;
  assign sum = {1'b0, acc} + {1'b0, rate};
  assign tick = enable && !clear && sum >= 33'(CLK_HZ);
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) acc <= '0;
    else if (clear) acc <= '0;
    else if (enable) acc <= tick ? 32'(sum - 33'(CLK_HZ)) : sum[31:0];
endmodule

// File: rtl/wav_stream_player.sv
// wav_stream_player: parses a 44-byte PCM WAV header from DDRAM and streams mono 16-bit samples
module wav_stream_player
  import wav_pkg::*;
#(
  parameter int unsigned CLK_HZ = 24000000,
  parameter int          ADDR_W = 28
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic              loop,
  input  logic              pause,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  input  logic              mem_ready,
  output logic [15:0]       pcm,
  output logic              sample_stb,
  output logic              playing,
  output logic              err,
  output logic              underrun
);
  logic [2:0] state, fb;
  logic [ADDR_W-1:0] base, ptr;
  logic [5:0] idx;
  logic [1:0] fidx;
  logic [15:0] ch, bits, l, r;
  logic [31:0] rate, size, rem, fbuf, size_n;
  logic [16:0] sum;
  logic pend, drop, bad, tick, got, hdr_ok, last, enable;
  assign got = pend && mem_ready;
  assign playing = state == ST_HDR || state == ST_FETCH || state == ST_HOLD;
  assign enable = (state == ST_FETCH || state == ST_HOLD) && !pause;
  assign fb = bits == 16'd16 ? (ch == 16'd2 ? 3'd4 : 3'd2) : (ch == 16'd2 ? 3'd2 : 3'd1);
  assign size_n = {mem_data, size[23:0]};
  assign hdr_ok = !bad && hdr_byte_ok(idx, mem_data) && (ch == 16'd1 || ch == 16'd2) &&
                  (bits == 16'd8 || bits == 16'd16) && rate != 32'd0 && rate <= CLK_HZ;
  assign last = rem - 32'(fb) < 32'(fb);
  assign l = bits == 16'd16 ? fbuf[15:0] : {fbuf[7:0] ^ 8'h80, 8'h00};
  assign r = bits == 16'd16 ? fbuf[31:16] : {fbuf[15:8] ^ 8'h80, 8'h00};
  assign sum = {l[15], l} + {r[15], r};
  wav_rate_gen #(.CLK_HZ(CLK_HZ)) u_rate (
    .clk_sys(clk_sys), .reset(reset), .rate(rate), .enable(enable), .clear(start), .tick(tick)
  );
  // drop marks an aborted read whose late mem_ready must be swallowed before reissuing
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state <= ST_IDLE; base <= '0; ptr <= '0; idx <= '0; fidx <= '0;
      ch <= '0; bits <= '0; rate <= '0; size <= '0; rem <= '0; fbuf <= '0;
      pend <= 1'b0; drop <= 1'b0; bad <= 1'b0; mem_rd <= 1'b0; mem_addr <= '0;
      pcm <= '0; sample_stb <= 1'b0; err <= 1'b0; underrun <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      sample_stb <= 1'b0;
      if (got) pend <= 1'b0;
      if (drop && mem_ready) drop <= 1'b0;
      if (start) begin
        state <= ST_HDR; base <= base_addr; ptr <= base_addr; idx <= '0; bad <= 1'b0;
        err <= 1'b0; underrun <= 1'b0; pend <= 1'b0; drop <= pend && !mem_ready;
      end else begin
        if ((state == ST_HDR || state == ST_FETCH) && !pend && !drop) begin
          mem_rd <= 1'b1; mem_addr <= ptr; pend <= 1'b1;
        end
        case (state)
          ST_HDR: if (got) begin
            ptr <= ptr + 1'b1; idx <= idx + 6'd1;
            bad <= bad || !hdr_byte_ok(idx, mem_data);
            if (idx[5:1] == CH_OFS[5:1]) ch[{idx[0], 3'b000} +: 8] <= mem_data;
            if (idx[5:1] == BITS_OFS[5:1]) bits[{idx[0], 3'b000} +: 8] <= mem_data;
            if (idx[5:2] == RATE_OFS[5:2]) rate[{idx[1:0], 3'b000} +: 8] <= mem_data;
            if (idx[5:2] == SIZE_OFS[5:2]) size[{idx[1:0], 3'b000} +: 8] <= mem_data;
            if (idx == DATA_OFS - 6'd1) begin
              if (!hdr_ok) begin state <= ST_ERROR; err <= 1'b1; end
              else if (size_n < 32'(fb)) state <= ST_DONE;
              else begin state <= ST_FETCH; rem <= size_n; fidx <= '0; end
            end
          end
          ST_FETCH: begin
            if (tick) underrun <= 1'b1;
            if (got) begin
              ptr <= ptr + 1'b1; fidx <= fidx + 2'd1;
              fbuf[{fidx, 3'b000} +: 8] <= mem_data;
              if ({1'b0, fidx} == fb - 3'd1) begin state <= ST_HOLD; fidx <= '0; end
            end
          end
          ST_HOLD: if (tick) begin
            pcm <= ch == 16'd2 ? 16'(sum >> 1) : l;
            sample_stb <= 1'b1;
            if (!last) begin rem <= rem - 32'(fb); state <= ST_FETCH; end
            else if (loop) begin rem <= size; ptr <= base + ADDR_W'(DATA_OFS); state <= ST_FETCH; end
            else state <= ST_DONE;
          end
          default: pcm <= '0;
        endcase
      end
    end
endmodule
